serial2parallel: RTL and testbench



---
 rtl/serial2parallel.sv | 81 ++++++++
 tb/tb_serial2parallel.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial2parallel.sv
// Deserializer: packs a qualified serial bit stream into WIDTH-bit words and
// hands each word out through a one-deep valid/ready output register.
module serial2parallel #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] base_s;
  logic [WIDTH-1:0] shifted_s;
  logic [CW-1:0]    cnt_base_s;
  logic [CW-1:0]    cnt_next_s;
  logic             complete_s;
  logic             load_s;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST) begin
      return {cur[WIDTH-2:0], b};
    end else begin
      return {b, cur[WIDTH-1:1]};
    end
  endfunction

  // Next shift/count state; sync restarts the word before this cycle's bit lands,
  // so a word that would have completed alongside sync can never complete.
  always_comb begin
    base_s     = sync ? {WIDTH{1'b0}} : shreg_r;
    cnt_base_s = sync ? {CW{1'b0}} : cnt_r;
    shifted_s  = shift_in(base_s, din);
    complete_s = 1'b0;
    cnt_next_s = cnt_base_s;
    if (din_valid) begin
      if (cnt_base_s == LAST) begin
        complete_s = 1'b1;
        cnt_next_s = {CW{1'b0}};
      end else begin
        cnt_next_s = cnt_base_s + ONE;
      end
    end else begin
      cnt_next_s = cnt_base_s;
    end
    load_s = complete_s & (~dout_valid | dout_ready);
  end

  // Shift register, bit counter and the one-deep output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_r    <= {WIDTH{1'b0}};
      cnt_r      <= {CW{1'b0}};
      dout       <= {WIDTH{1'b0}};
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      shreg_r <= din_valid ? shifted_s : base_s;
      cnt_r   <= cnt_next_s;
      overrun <= complete_s & dout_valid & ~dout_ready;
      if (load_s) begin
        dout       <= shifted_s;
        dout_valid <= 1'b1;
      end else if (dout_valid & dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial2parallel.sv
// Bench for serial2parallel: directed vector table (WIDTH=4, MSB first), a
// directed LSB-first WIDTH=8 word, then random traffic against a bit-list model.
module tb_serial2parallel;

  logic       clk = 1'b0;
  logic       rst_a, dv_a, din_a, sync_a, rdy_a;
  logic [3:0] dout_a;
  logic       vld_a, ovr_a;
  logic       rst_b, dv_b, din_b, sync_b, rdy_b;
  logic [7:0] dout_b;
  logic       vld_b, ovr_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  serial2parallel #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .din_valid(dv_a), .din(din_a), .sync(sync_a),
    .dout(dout_a), .dout_valid(vld_a), .dout_ready(rdy_a), .overrun(ovr_a));

  serial2parallel #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .din_valid(dv_b), .din(din_b), .sync(sync_b),
    .dout(dout_b), .dout_valid(vld_b), .dout_ready(rdy_b), .overrun(ovr_b));

  // Reference model: count of bits in the current word, its accumulated value,
  // and the output buffer contents, one entry per DUT.
  int          nb[2];
  logic [31:0] acc[2];
  logic [31:0] held[2];
  bit          mvld[2];
  bit          movr[2];

  typedef struct {
    bit       rst, dv, d, sy, rdy;
    bit       ev;
    bit [3:0] ed;
    bit       eo;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic model_step(input int k, input int w, input bit msb,
                            input bit r, input bit dv, input bit d, input bit sy, input bit rdy);
    bit          done;
    logic [31:0] word;
    done = 1'b0;
    word = 32'd0;
    if (r) begin
      nb[k] = 0; acc[k] = 32'd0; held[k] = 32'd0; mvld[k] = 1'b0; movr[k] = 1'b0;
      return;
    end
    if (sy) begin
      nb[k] = 0; acc[k] = 32'd0;
    end
    if (dv) begin
      if (d) acc[k] = acc[k] | (32'd1 << (msb ? (w - 1 - nb[k]) : nb[k]));
      nb[k]++;
      if (nb[k] == w) begin
        done = 1'b1; word = acc[k]; nb[k] = 0; acc[k] = 32'd0;
      end
    end
    movr[k] = 1'b0;
    if (done) begin
      if (!mvld[k] || rdy) begin
        held[k] = word; mvld[k] = 1'b1;
      end else begin
        movr[k] = 1'b1;
      end
    end else if (mvld[k] && rdy) begin
      mvld[k] = 1'b0;
    end
  endtask

  // Advance one clock with the currently driven inputs and check both DUTs against the model.
  task automatic step();
    model_step(0, 4, 1'b1, rst_a, dv_a, din_a, sync_a, rdy_a);
    model_step(1, 8, 1'b0, rst_b, dv_b, din_b, sync_b, rdy_b);
    @(posedge clk);
    #1;
    chk("model_valid_a", 32'(vld_a), 32'(mvld[0]));
    chk("model_overrun_a", 32'(ovr_a), 32'(movr[0]));
    if (mvld[0]) chk("model_dout_a", 32'(dout_a), held[0] & 32'hF);
    chk("model_valid_b", 32'(vld_b), 32'(mvld[1]));
    chk("model_overrun_b", 32'(ovr_b), 32'(movr[1]));
    if (mvld[1]) chk("model_dout_b", 32'(dout_b), held[1] & 32'hFF);
  endtask

  task automatic row(input bit r, input bit dv, input bit d, input bit sy, input bit rdy,
                     input bit ev, input bit [3:0] ed, input bit eo);
    vec_t v;
    v.rst = r; v.dv = dv; v.d = d; v.sy = sy; v.rdy = rdy; v.ev = ev; v.ed = ed; v.eo = eo;
    tbl.push_back(v);
  endtask

  initial begin
    rst_a = 1'b1; dv_a = 1'b0; din_a = 1'b0; sync_a = 1'b0; rdy_a = 1'b1;
    rst_b = 1'b1; dv_b = 1'b0; din_b = 1'b0; sync_b = 1'b0; rdy_b = 1'b1;

    //   rst dv  d  sy rdy  ev  ed    eo
    row(1, 1, 1, 0, 1, 0, 4'h0, 0);                 // reset state
    row(0, 1, 1, 0, 1, 0, 4'h0, 0);                 // 1,0,1,1 back to back
    row(0, 1, 0, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 1, 1, 4'hB, 0);
    row(0, 0, 0, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 1, 0, 4'h0, 0);                 // same bits, two gaps before the last
    row(0, 1, 0, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 1, 0, 4'h0, 0);
    row(0, 0, 0, 0, 1, 0, 4'h0, 0);
    row(0, 0, 1, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 1, 1, 4'hB, 0);
    row(0, 0, 0, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 0, 0, 4'h0, 0);                 // 0xA then 0x5 under backpressure
    row(0, 1, 0, 0, 0, 0, 4'h0, 0);
    row(0, 1, 1, 0, 0, 0, 4'h0, 0);
    row(0, 1, 0, 0, 0, 1, 4'hA, 0);
    row(0, 1, 0, 0, 0, 1, 4'hA, 0);
    row(0, 1, 1, 0, 0, 1, 4'hA, 0);
    row(0, 1, 0, 0, 0, 1, 4'hA, 0);
    row(0, 1, 1, 0, 0, 1, 4'hA, 1);
    row(0, 0, 0, 0, 0, 1, 4'hA, 0);
    row(0, 0, 0, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 0, 0, 4'h0, 0);                 // ready only on 0x5's completion edge
    row(0, 1, 0, 0, 0, 0, 4'h0, 0);
    row(0, 1, 1, 0, 0, 0, 4'h0, 0);
    row(0, 1, 0, 0, 0, 1, 4'hA, 0);
    row(0, 1, 0, 0, 0, 1, 4'hA, 0);
    row(0, 1, 1, 0, 0, 1, 4'hA, 0);
    row(0, 1, 0, 0, 0, 1, 4'hA, 0);
    row(0, 1, 1, 0, 1, 1, 4'h5, 0);
    row(0, 0, 0, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 1, 0, 4'h0, 0);                 // 1,1 then sync with bit 0
    row(0, 1, 1, 0, 1, 0, 4'h0, 0);
    row(0, 1, 0, 1, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 1, 0, 4'h0, 0);
    row(0, 1, 0, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 1, 1, 4'h5, 0);
    row(0, 0, 0, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 1, 0, 4'h0, 0);                 // reset mid-word
    row(0, 1, 1, 0, 1, 0, 4'h0, 0);
    row(1, 1, 1, 0, 1, 0, 4'h0, 0);
    row(0, 1, 0, 0, 1, 0, 4'h0, 0);
    row(0, 1, 0, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 1, 1, 4'h3, 0);
    row(0, 0, 0, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 0, 0, 4'h0, 0);                 // held word survives sync on a would-be completion
    row(0, 1, 1, 0, 0, 0, 4'h0, 0);
    row(0, 1, 1, 0, 0, 0, 4'h0, 0);
    row(0, 1, 1, 0, 0, 1, 4'hF, 0);
    row(0, 1, 0, 0, 0, 1, 4'hF, 0);
    row(0, 1, 0, 0, 0, 1, 4'hF, 0);
    row(0, 1, 0, 0, 0, 1, 4'hF, 0);
    row(0, 1, 1, 1, 0, 1, 4'hF, 0);
    row(0, 0, 0, 0, 1, 0, 4'h0, 0);
    row(0, 1, 0, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 1, 0, 4'h0, 0);
    row(0, 1, 0, 0, 1, 1, 4'hA, 0);
    row(0, 0, 0, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 1, 0, 4'h0, 0);                 // 1011_0110 continuous: words 4 cycles apart
    row(0, 1, 0, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 1, 1, 4'hB, 0);
    row(0, 1, 0, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 1, 0, 4'h0, 0);
    row(0, 1, 1, 0, 1, 0, 4'h0, 0);
    row(0, 1, 0, 0, 1, 1, 4'h6, 0);
    row(0, 0, 0, 0, 1, 0, 4'h0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_a = tbl[i].rst; dv_a = tbl[i].dv; din_a = tbl[i].d;
      sync_a = tbl[i].sy; rdy_a = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(vld_a), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_overrun", i), 32'(ovr_a), 32'(tbl[i].eo));
      if (tbl[i].ev || tbl[i].rst) chk($sformatf("vec%0d_dout", i), 32'(dout_a), 32'(tbl[i].ed));
    end

    // LSB-first, WIDTH=8: first bit lands in dout[0]
    rst_a = 1'b0; dv_a = 1'b0; sync_a = 1'b0; rdy_a = 1'b1;
    chk("b_reset_valid", 32'(vld_b), 32'd0);
    chk("b_reset_dout", 32'(dout_b), 32'd0);
    rst_b = 1'b0; rdy_b = 1'b1; dv_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din_b = (i == 0);
      step();
      if (i < 7) chk("b_no_early_valid", 32'(vld_b), 32'd0);
    end
    chk("b_word_valid", 32'(vld_b), 32'd1);
    chk("b_word_dout", 32'(dout_b), 32'h01);
    dv_b = 1'b0;
    step();
    chk("b_drained", 32'(vld_b), 32'd0);

    // random traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      rst_a  = ($urandom_range(0, 99) == 0);
      dv_a   = ($urandom_range(0, 3) != 0);
      din_a  = $urandom_range(0, 1);
      sync_a = ($urandom_range(0, 19) == 0);
      rdy_a  = $urandom_range(0, 1);
      rst_b  = ($urandom_range(0, 99) == 0);
      dv_b   = ($urandom_range(0, 3) != 0);
      din_b  = $urandom_range(0, 1);
      sync_b = ($urandom_range(0, 29) == 0);
      rdy_b  = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
